// File: rtl/pong_game_ctrl.sv
// Pong match sequencer: idle/serve/rally/point/over state machine, score keeping
// and ball load/enable/step control for the display datapath, paced by frame_tick.
module pong_game_ctrl #(
    parameter int WIN_SCORE    = 7,
    parameter int SERVE_FRAMES = 60,
    parameter int POINT_FRAMES = 90,
    parameter int STEP_SLOW    = 2,
    parameter int STEP_FAST    = 4,
    parameter int STEP_MAX     = 8,
    parameter int RALLY_HITS   = 4
) (
    input  logic       vga_clk,
    input  logic       sys_rst,
    input  logic       frame_tick,
    input  logic       start,
    input  logic       speed_sel,
    input  logic       miss_left,
    input  logic       miss_right,
    input  logic       paddle_hit,
    output logic       ball_load,
    output logic       ball_en,
    output logic       serve_dir,
    output logic [3:0] ball_step,
    output logic [3:0] score_l,
    output logic [3:0] score_r,
    output logic       game_over,
    output logic       winner,
    output logic [2:0] state_o
);

    localparam int FMAX = (SERVE_FRAMES > POINT_FRAMES) ? SERVE_FRAMES : POINT_FRAMES;
    localparam int FW   = $clog2(FMAX + 1);
    localparam int HW   = (RALLY_HITS > 1) ? $clog2(RALLY_HITS + 1) : 1;

    localparam logic [3:0] STEP_SLOW_V = 4'(STEP_SLOW);
    localparam logic [3:0] STEP_FAST_V = 4'(STEP_FAST);
    localparam logic [3:0] STEP_MAX_V  = 4'(STEP_MAX);
    localparam logic [3:0] WIN_V       = 4'(WIN_SCORE);
    localparam logic [3:0] SCORE_SAT   = 4'd15;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SERVE = 3'd1,
        ST_RALLY = 3'd2,
        ST_POINT = 3'd3,
        ST_OVER  = 3'd4
    } state_t;

    state_t          state_reg, state_next;
    logic            start_q_reg;
    logic            armed_reg;
    logic [FW-1:0]   frame_cnt_reg, frame_cnt_next;
    logic [HW-1:0]   hit_cnt_reg, hit_cnt_next;
    logic [3:0]      step_reg, step_next;
    logic [3:0]      score_reg [2];
    logic [3:0]      score_next [2];
    logic [3:0]      score_inc [2];
    logic            dir_reg, dir_next;
    logic            load_reg, load_next;
    logic            ball_en_reg, ball_en_next;
    logic            over_reg, over_next;
    logic            winner_reg, winner_next;

    logic            start_rise;
    logic            forced_idle;
    logic            serve_done;
    logic            point_done;
    logic            win_reached;
    logic            miss_l_only;
    logic            miss_r_only;
    logic            miss_any;
    logic [3:0]      step_init;
    logic [3:0]      step_bump;

    // armed_reg blocks a game from starting when start is already high out of reset
    assign start_rise  = start & ~start_q_reg & armed_reg;
    assign forced_idle = (state_reg != ST_IDLE) && !start;
    assign serve_done  = (state_reg == ST_SERVE) && frame_tick &&
                         (frame_cnt_reg == FW'(SERVE_FRAMES - 1));
    assign point_done  = (state_reg == ST_POINT) && frame_tick &&
                         (frame_cnt_reg == FW'(POINT_FRAMES - 1));
    assign win_reached = (score_reg[0] == WIN_V) || (score_reg[1] == WIN_V);
    assign miss_any    = miss_left | miss_right;
    assign miss_l_only = miss_left & ~miss_right;
    assign miss_r_only = miss_right & ~miss_left;
    assign step_init   = speed_sel ? STEP_FAST_V : STEP_SLOW_V;
    assign step_bump   = (step_reg >= STEP_MAX_V) ? STEP_MAX_V : step_reg + 4'd1;

    // index 0 = left player, 1 = right player
    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_score
            assign score_inc[gi] = (score_reg[gi] == SCORE_SAT) ? SCORE_SAT
                                                                : score_reg[gi] + 4'd1;
        end
    endgenerate

    always_ff @(posedge vga_clk) begin
        if (sys_rst) begin
            state_reg     <= ST_IDLE;
            start_q_reg   <= 1'b0;
            armed_reg     <= 1'b0;
            frame_cnt_reg <= '0;
            hit_cnt_reg   <= '0;
            step_reg      <= STEP_SLOW_V;
            for (int i = 0; i < 2; i++) begin
                score_reg[i] <= 4'd0;
            end
            dir_reg       <= 1'b0;
            load_reg      <= 1'b0;
            ball_en_reg   <= 1'b0;
            over_reg      <= 1'b0;
            winner_reg    <= 1'b0;
        end else begin
            state_reg     <= state_next;
            start_q_reg   <= start;
            armed_reg     <= armed_reg | ~start;
            frame_cnt_reg <= frame_cnt_next;
            hit_cnt_reg   <= hit_cnt_next;
            step_reg      <= step_next;
            for (int i = 0; i < 2; i++) begin
                score_reg[i] <= score_next[i];
            end
            dir_reg       <= dir_next;
            load_reg      <= load_next;
            ball_en_reg   <= ball_en_next;
            over_reg      <= over_next;
            winner_reg    <= winner_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        if (forced_idle) begin
            state_next = ST_IDLE;
        end else begin
            case (state_reg)
                ST_IDLE:  if (start_rise) state_next = ST_SERVE;
                ST_SERVE: if (serve_done) state_next = ST_RALLY;
                ST_RALLY: if (miss_any)   state_next = ST_POINT;
                ST_POINT: if (point_done) state_next = win_reached ? ST_OVER : ST_SERVE;
                ST_OVER:  state_next = ST_OVER;
                default:  state_next = ST_IDLE;
            endcase
        end
    end

    always_comb begin
        frame_cnt_next = frame_cnt_reg;
        hit_cnt_next   = hit_cnt_reg;
        step_next      = step_reg;
        score_next[0]  = score_reg[0];
        score_next[1]  = score_reg[1];
        dir_next       = dir_reg;
        winner_next    = winner_reg;
        load_next      = 1'b0;

        if (!forced_idle) begin
            case (state_reg)
                ST_IDLE: begin
                    if (start_rise) begin
                        score_next[0] = 4'd0;
                        score_next[1] = 4'd0;
                        dir_next      = 1'b1;
                        step_next     = step_init;
                        hit_cnt_next  = '0;
                        load_next     = 1'b1;
                    end
                end
                ST_SERVE: begin
                    if (frame_tick) frame_cnt_next = frame_cnt_reg + FW'(1);
                end
                ST_RALLY: begin
                    // a miss always wins over a simultaneous paddle hit
                    if (miss_l_only) begin
                        score_next[1] = score_inc[1];
                        dir_next      = 1'b0;
                    end else if (miss_r_only) begin
                        score_next[0] = score_inc[0];
                        dir_next      = 1'b1;
                    end else if (!miss_any && paddle_hit) begin
                        if (hit_cnt_reg == HW'(RALLY_HITS - 1)) begin
                            hit_cnt_next = '0;
                            step_next    = step_bump;
                        end else begin
                            hit_cnt_next = hit_cnt_reg + HW'(1);
                        end
                    end
                end
                ST_POINT: begin
                    if (frame_tick) frame_cnt_next = frame_cnt_reg + FW'(1);
                    if (point_done) begin
                        if (win_reached) begin
                            winner_next = (score_reg[1] == WIN_V);
                        end else begin
                            step_next    = step_init;
                            hit_cnt_next = '0;
                            load_next    = 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end

        // every state change starts the frame count afresh
        if (state_next != state_reg) frame_cnt_next = '0;
        ball_en_next = (state_next == ST_RALLY);
        over_next    = (state_next == ST_OVER);
    end

    assign ball_load = load_reg;
    assign ball_en   = ball_en_reg;
    assign serve_dir = dir_reg;
    assign ball_step = step_reg;
    assign score_l   = score_reg[0];
    assign score_r   = score_reg[1];
    assign game_over = over_reg;
    assign winner    = winner_reg;
    assign state_o   = state_reg;

endmodule

// File: tb/tb_pong_game_ctrl.sv
// Directed-plus-random bench for pong_game_ctrl; a rule-level match model predicts
// every output each cycle, and directed steps check the headline scenarios.
module tb_pong_game_ctrl;

    localparam int WIN          = 7;
    localparam int SERVE_FRAMES = 60;
    localparam int POINT_FRAMES = 90;
    localparam int STEP_SLOW    = 2;
    localparam int STEP_FAST    = 4;
    localparam int STEP_MAX     = 8;
    localparam int RALLY_HITS   = 4;

    localparam int S_IDLE = 0, S_SERVE = 1, S_RALLY = 2, S_POINT = 3, S_OVER = 4;

    logic       vga_clk = 1'b0;
    logic       sys_rst, frame_tick, start, speed_sel;
    logic       miss_left, miss_right, paddle_hit;
    logic       ball_load, ball_en, serve_dir, game_over, winner;
    logic [3:0] ball_step, score_l, score_r;
    logic [2:0] state_o;

    int checks = 0;
    int errors = 0;

    // match model
    int m_state, m_sl, m_sr, m_step, m_hits, m_frames;
    bit m_dir, m_load, m_winner, m_start_q, m_seen_low;

    pong_game_ctrl dut (
        .vga_clk    (vga_clk),
        .sys_rst    (sys_rst),
        .frame_tick (frame_tick),
        .start      (start),
        .speed_sel  (speed_sel),
        .miss_left  (miss_left),
        .miss_right (miss_right),
        .paddle_hit (paddle_hit),
        .ball_load  (ball_load),
        .ball_en    (ball_en),
        .serve_dir  (serve_dir),
        .ball_step  (ball_step),
        .score_l    (score_l),
        .score_r    (score_r),
        .game_over  (game_over),
        .winner     (winner),
        .state_o    (state_o)
    );

    always #5 vga_clk = ~vga_clk;

    function automatic int sat_inc(input int v, input int cap);
        return (v >= cap) ? cap : v + 1;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // applies the match rules to the inputs present at this clock edge
    task automatic model_edge();
        bit rise;
        rise   = start && !m_start_q && m_seen_low;
        m_load = 0;
        if (sys_rst) begin
            m_state = S_IDLE; m_sl = 0; m_sr = 0; m_dir = 0; m_step = STEP_SLOW;
            m_hits = 0; m_frames = 0; m_winner = 0; m_start_q = 0; m_seen_low = 0;
        end else begin
            if (m_state != S_IDLE && !start) begin
                m_state  = S_IDLE;
                m_frames = 0;
            end else begin
                case (m_state)
                    S_IDLE: if (rise) begin
                        m_sl = 0; m_sr = 0; m_dir = 1; m_hits = 0; m_load = 1;
                        m_step  = speed_sel ? STEP_FAST : STEP_SLOW;
                        m_state = S_SERVE;
                    end
                    S_SERVE: if (frame_tick) begin
                        m_frames++;
                        if (m_frames == SERVE_FRAMES) begin
                            m_frames = 0;
                            m_state  = S_RALLY;
                        end
                    end
                    S_RALLY: begin
                        if (miss_left && miss_right) begin
                            m_state = S_POINT;
                        end else if (miss_left) begin
                            m_sr = sat_inc(m_sr, 15); m_dir = 0; m_state = S_POINT;
                        end else if (miss_right) begin
                            m_sl = sat_inc(m_sl, 15); m_dir = 1; m_state = S_POINT;
                        end else if (paddle_hit) begin
                            m_hits++;
                            if (m_hits == RALLY_HITS) begin
                                m_hits = 0;
                                m_step = sat_inc(m_step, STEP_MAX);
                            end
                        end
                    end
                    S_POINT: if (frame_tick) begin
                        m_frames++;
                        if (m_frames == POINT_FRAMES) begin
                            m_frames = 0;
                            if (m_sl == WIN || m_sr == WIN) begin
                                m_state  = S_OVER;
                                m_winner = (m_sr == WIN);
                            end else begin
                                m_step  = speed_sel ? STEP_FAST : STEP_SLOW;
                                m_hits  = 0;
                                m_load  = 1;
                                m_state = S_SERVE;
                            end
                        end
                    end
                    default: ;
                endcase
            end
            m_start_q = start;
            if (!start) m_seen_low = 1;
        end
    endtask

    task automatic compare_all();
        check("state_o",   state_o,   m_state);
        check("ball_load", ball_load, m_load);
        check("ball_en",   ball_en,   m_state == S_RALLY);
        check("serve_dir", serve_dir, m_dir);
        check("ball_step", ball_step, m_step);
        check("score_l",   score_l,   m_sl);
        check("score_r",   score_r,   m_sr);
        check("game_over", game_over, m_state == S_OVER);
        check("load_en_excl", ball_load & ball_en, 0);
        if (m_state == S_OVER) check("winner", winner, m_winner);
    endtask

    task automatic tick_cycle();
        @(posedge vga_clk);
        model_edge();
        #1;
        compare_all();
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            frame_tick = ($urandom_range(0, 2) == 0);
            tick_cycle();
            frame_tick = 1'b0;
        end
    endtask

    task automatic pulse(input bit ml, input bit mr, input bit ph);
        miss_left  = ml;
        miss_right = mr;
        paddle_hit = ph;
        frame_tick = ($urandom_range(0, 2) == 0);
        tick_cycle();
        miss_left  = 1'b0;
        miss_right = 1'b0;
        paddle_hit = 1'b0;
        frame_tick = 1'b0;
        $display("pulse ml=%0d mr=%0d hit=%0d -> state=%0d score=%0d/%0d step=%0d dir=%0d",
                 ml, mr, ph, state_o, score_l, score_r, ball_step, serve_dir);
    endtask

    // stays while the model sits in cur; stray pulses outside RALLY must be ignored
    task automatic run_while(input int cur, input int budget);
        int n = 0;
        while (m_state == cur && n < budget) begin
            frame_tick = ($urandom_range(0, 2) == 0);
            if (cur != S_RALLY) begin
                miss_left  = ($urandom_range(0, 15) == 0);
                miss_right = ($urandom_range(0, 15) == 0);
                paddle_hit = ($urandom_range(0, 15) == 0);
            end
            tick_cycle();
            frame_tick = 1'b0; miss_left = 1'b0; miss_right = 1'b0; paddle_hit = 1'b0;
            n++;
        end
        check("wait_exit", state_o != 3'(cur), 1);
        $display("left state %0d after %0d cycles -> state=%0d load=%0d step=%0d",
                 cur, n, state_o, ball_load, ball_step);
    endtask

    initial begin
        int guard;
        sys_rst = 1'b1; start = 1'b0; speed_sel = 1'b0; frame_tick = 1'b0;
        miss_left = 1'b0; miss_right = 1'b0; paddle_hit = 1'b0;
        tick_cycle();
        tick_cycle();
        check("rst_state", state_o, 0);
        check("rst_step",  ball_step, 2);
        check("rst_score", {score_l, score_r}, 0);
        sys_rst = 1'b0;
        idle_cycles(3);

        // first serve, slow speed
        start = 1'b1;
        tick_cycle();
        check("serve_load",  ball_load, 1);
        check("serve_state", state_o, 1);
        check("serve_step",  ball_step, 2);
        check("serve_dir0",  serve_dir, 1);
        tick_cycle();
        check("load_one_cycle", ball_load, 0);
        run_while(S_SERVE, 2000);
        check("rally_state", state_o, 2);
        check("rally_en",    ball_en, 1);

        // left misses, speed switched to fast during the pause
        pulse(1, 0, 0);
        check("missl_score_r", score_r, 1);
        check("missl_dir",     serve_dir, 0);
        check("missl_state",   state_o, 3);
        speed_sel = 1'b1;
        run_while(S_POINT, 2000);
        check("reserve_state", state_o, 1);
        check("reserve_load",  ball_load, 1);
        check("reserve_step",  ball_step, 4);

        // step ramp and saturation
        run_while(S_SERVE, 2000);
        for (int i = 0; i < 9; i++) begin
            pulse(0, 0, 1);
            idle_cycles($urandom_range(0, 2));
        end
        check("ramp_step6", ball_step, 6);
        for (int i = 0; i < 3; i++) pulse(0, 0, 1);
        check("ramp_step7", ball_step, 7);
        for (int i = 0; i < 12; i++) pulse(0, 0, 1);
        check("ramp_sat8", ball_step, 8);

        // double miss, then miss with simultaneous hit
        pulse(1, 1, 0);
        check("dbl_state", state_o, 3);
        check("dbl_score", {score_l, score_r}, {4'd0, 4'd1});
        run_while(S_POINT, 2000);
        run_while(S_SERVE, 2000);
        pulse(0, 1, 1);
        check("hitmiss_score_l", score_l, 1);
        check("hitmiss_step",    ball_step, 4);
        check("hitmiss_dir",     serve_dir, 1);

        // right player runs the score to the winning total
        run_while(S_POINT, 2000);
        guard = 0;
        while (m_sr < WIN && guard < 12) begin
            run_while(S_SERVE, 2000);
            for (int h = $urandom_range(0, 6); h > 0; h--) begin
                pulse(0, 0, 1);
                idle_cycles($urandom_range(0, 3));
            end
            pulse(1, 0, 0);
            run_while(S_POINT, 2000);
            guard++;
        end
        check("over_state",  state_o, 4);
        check("over_flag",   game_over, 1);
        check("over_winner", winner, 1);
        pulse(1, 0, 0);
        pulse(0, 1, 1);
        idle_cycles(5);
        check("over_score_r", score_r, 7);

        // leave via IDLE, new game, drop start mid-rally
        start = 1'b0;
        tick_cycle();
        check("drop_over_state", state_o, 0);
        check("drop_over_flag",  game_over, 0);
        check("drop_over_score", score_r, 7);
        start = 1'b1;
        tick_cycle();
        check("new_state", state_o, 1);
        check("new_score", {score_l, score_r}, 0);
        run_while(S_SERVE, 2000);
        pulse(0, 1, 0);
        run_while(S_POINT, 2000);
        run_while(S_SERVE, 2000);
        pulse(0, 0, 1);
        pulse(0, 0, 1);
        start = 1'b0;
        tick_cycle();
        check("drop_state",   state_o, 0);
        check("drop_en",      ball_en, 0);
        check("drop_score_l", score_l, 1);
        idle_cycles(2);

        // reset mid-serve with start held high through release
        start = 1'b1;
        tick_cycle();
        idle_cycles(4);
        sys_rst = 1'b1;
        tick_cycle();
        check("midrst_state", state_o, 0);
        check("midrst_step",  ball_step, 2);
        check("midrst_score", {score_l, score_r}, 0);
        check("midrst_dir",   serve_dir, 0);
        sys_rst = 1'b0;
        idle_cycles(6);
        check("held_start_idle", state_o, 0);
        start = 1'b0;
        tick_cycle();
        start = 1'b1;
        tick_cycle();
        check("retoggle_state", state_o, 1);
        check("retoggle_step",  ball_step, 4);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
